// File: rtl/chip8_draw_ctrl.sv
// chip8_draw_ctrl -- CHIP-8 DXYN sprite draw and 00E0 clear sequencer.
//
// Draws an 8-pixel-wide, N-row sprite from program memory into a 64x32 one-bit
// framebuffer stored as 256 bytes (fb_addr = {row[4:0], byte[2:0]}, bit 7 leftmost).
// Each sprite row is XORed into two adjacent framebuffer bytes with a six-state
// sequence: fetch, fetch wait, read left, read right, write left, write right.
// Framebuffer accesses only proceed while the VGA arbiter grants the port.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, cls           DXYN / 00E0 request pulses (accepted only when idle, cls wins)
//   x_in, y_in, n_in     draw coordinates and row count
//   i_addr               sprite base address in program memory
//   busy, done           operation in progress / one-cycle completion pulse
//   collision            VF result of the last draw (0 after a clear)
//   mem_rd/addr/rdata    program memory read port, 1-cycle latency
//   fb_gnt               framebuffer grant
//   fb_rd/we/addr/wdata/rdata  framebuffer port, 1-cycle read latency
//
// Configuration:
//   DRAW_WRAP_EN  defined   -> pixels past the right/bottom edge wrap around.
//                 undefined -> such pixels are clipped (no strobes, no collision).
module chip8_draw_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cls,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] i_addr,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        fb_gnt,
    output logic        fb_rd,
    output logic        fb_we,
    output logic [7:0]  fb_addr,
    output logic [7:0]  fb_wdata,
    input  logic [7:0]  fb_rdata
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StFwait, StRdl, StRdr, StWrl, StWrr, StClear, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  row_q, row_d;
    logic [11:0] i_q, i_d;
    logic [15:0] spr_q, spr_d;
    logic [7:0]  old_l_q, old_l_d;
    logic [7:0]  old_r_q, old_r_d;
    logic        pend_l_q, pend_l_d;
    logic        pend_r_q, pend_r_d;
    logic        coll_q, coll_d;
    logic [7:0]  clr_q, clr_d;

    // Screen row carries one extra bit so the bottom edge can be detected.
    logic [5:0]  scr_row;
    logic [2:0]  lbyte, rbyte;
    logic        row_vis, right_vis;

    assign scr_row = {1'b0, y_q} + {2'b00, row_q};
    assign lbyte   = x_q[5:3];
    assign rbyte   = lbyte + 3'd1;

`ifdef DRAW_WRAP_EN
    assign row_vis   = 1'b1;
    assign right_vis = 1'b1;
`else
    assign row_vis   = ~scr_row[5];
    assign right_vis = (lbyte != 3'd7);
`endif

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        n_d       = n_q;
        row_d     = row_q;
        i_d       = i_q;
        spr_d     = spr_q;
        old_l_d   = old_l_q;
        old_r_d   = old_r_q;
        pend_l_d  = 1'b0;
        pend_r_d  = 1'b0;
        coll_d    = coll_q;
        clr_d     = clr_q;
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = 12'h000;
        fb_rd     = 1'b0;
        fb_we     = 1'b0;
        fb_addr   = 8'h00;
        fb_wdata  = 8'h00;

        // Read data arrives the cycle after a granted read, whatever the grant does then.
        if (pend_l_q) old_l_d = fb_rdata;
        if (pend_r_q) old_r_d = fb_rdata;

        case (state_q)
            StIdle: begin
                if (cls) begin
                    coll_d  = 1'b0;
                    clr_d   = 8'h00;
                    state_d = StClear;
                end else if (start) begin
                    x_d     = x_in[5:0];
                    y_d     = y_in[4:0];
                    n_d     = n_in;
                    i_d     = i_addr;
                    row_d   = 4'd0;
                    coll_d  = 1'b0;
                    state_d = (n_in == 4'd0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                mem_rd   = 1'b1;
                mem_addr = i_q + {8'h00, row_q};
                state_d  = StFwait;
            end
            StFwait: begin
                spr_d   = {mem_rdata, 8'h00} >> x_q[2:0];
                state_d = StRdl;
            end
            StRdl: begin
                if (fb_gnt) begin
                    fb_rd    = row_vis;
                    fb_addr  = row_vis ? {scr_row[4:0], lbyte} : 8'h00;
                    pend_l_d = row_vis;
                    state_d  = StRdr;
                end
            end
            StRdr: begin
                if (fb_gnt) begin
                    fb_rd    = row_vis && right_vis;
                    fb_addr  = (row_vis && right_vis) ? {scr_row[4:0], rbyte} : 8'h00;
                    pend_r_d = row_vis && right_vis;
                    state_d  = StWrl;
                end
            end
            StWrl: begin
                if (fb_gnt) begin
                    if (row_vis) begin
                        fb_we    = 1'b1;
                        fb_addr  = {scr_row[4:0], lbyte};
                        fb_wdata = old_l_q ^ spr_q[15:8];
                        if ((old_l_q & spr_q[15:8]) != 8'h00) coll_d = 1'b1;
                    end
                    state_d = StWrr;
                end
            end
            StWrr: begin
                if (fb_gnt) begin
                    if (row_vis && right_vis) begin
                        fb_we    = 1'b1;
                        fb_addr  = {scr_row[4:0], rbyte};
                        fb_wdata = old_r_q ^ spr_q[7:0];
                        if ((old_r_q & spr_q[7:0]) != 8'h00) coll_d = 1'b1;
                    end
                    row_d   = row_q + 4'd1;
                    state_d = ((row_q + 4'd1) == n_q) ? StDone : StFetch;
                end
            end
            StClear: begin
                if (fb_gnt) begin
                    fb_we   = 1'b1;
                    fb_addr = clr_q;
                    clr_d   = clr_q + 8'd1;
                    if (clr_q == 8'hFF) state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign collision = coll_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            n_q      <= '0;
            row_q    <= '0;
            i_q      <= '0;
            spr_q    <= '0;
            old_l_q  <= '0;
            old_r_q  <= '0;
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            coll_q   <= 1'b0;
            clr_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            n_q      <= n_d;
            row_q    <= row_d;
            i_q      <= i_d;
            spr_q    <= spr_d;
            old_l_q  <= old_l_d;
            old_r_q  <= old_r_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            coll_q   <= coll_d;
            clr_q    <= clr_d;
        end
    end

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// Testbench for chip8_draw_ctrl: pixel-level reference model feeding a scoreboard,
// with a monitor that checks each done pulse against the queued expectation.
`timescale 1ns/1ps
module tb_chip8_draw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cls = 1'b0;
    logic [7:0]  x_in = 8'h00;
    logic [7:0]  y_in = 8'h00;
    logic [3:0]  n_in = 4'h0;
    logic [11:0] i_addr = 12'h000;
    logic        busy, done, collision, mem_rd, fb_rd, fb_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        fb_gnt = 1'b1;
    logic [7:0]  fb_addr, fb_wdata;
    logic [7:0]  fb_rdata = 8'h00;

    chip8_draw_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cls(cls),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_addr(i_addr),
        .busy(busy), .done(done), .collision(collision),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .fb_gnt(fb_gnt), .fb_rd(fb_rd), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int gnt_mode = 0;            // 0 full grant, 1 toggle, 2 random
    bit last_coll = 1'b0;

    logic [7:0] mem    [4096];
    logic [7:0] fb_mem [256];
    logic [7:0] ref_fb [256];

    bit           exp_coll_q[$];
    int           exp_lat_q[$];
    logic [2047:0] exp_fb_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Program memory and framebuffer RAM models, both one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (fb_rd) fb_rdata <= fb_mem[fb_addr];
        if (fb_we) fb_mem[fb_addr] <= fb_wdata;
    end

    // Grant generation plus per-cycle protocol checks.
    always @(negedge clk) begin
        case (gnt_mode)
            0:       fb_gnt = 1'b1;
            1:       fb_gnt = ~fb_gnt;
            default: fb_gnt = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (!rst) begin
            if (fb_we) we_cnt++;
            if (fb_rd && fb_we) begin
                n_tests++; n_fail++;
                $display("FAIL rd_we_overlap: got fb_rd=1 fb_we=1, expected at most one");
            end
            if ((fb_rd || fb_we) && !fb_gnt) begin
                n_tests++; n_fail++;
                $display("FAIL strobe_without_grant: got strobe=1 with fb_gnt=0, expected 0");
            end
            if (mem_rd && !busy) begin
                n_tests++; n_fail++;
                $display("FAIL mem_rd_idle: got mem_rd=1 with busy=0, expected 0");
            end
        end
    end

    // Scoreboard monitor: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        #2;
        if (!rst && done) begin
            done_cnt++;
            if (exp_coll_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                bit            ec;
                int            el;
                logic [2047:0] ef;
                int            bad;
                ec = exp_coll_q.pop_front();
                el = exp_lat_q.pop_front();
                ef = exp_fb_q.pop_front();
                chk("collision", 32'(collision), 32'(ec));
                chk("busy_at_done", 32'(busy), 32'd0);
                if (el >= 0) chk("done_latency", cyc - accept_cyc, el);
                bad = -1;
                for (int a = 0; a < 256; a++)
                    if (bad < 0 && fb_mem[a] !== ef[a*8 +: 8]) bad = a;
                n_tests++;
                if (bad >= 0) begin
                    n_fail++;
                    $display("FAIL framebuffer: byte %0d got %0h, expected %0h",
                             bad, fb_mem[bad], ef[bad*8 +: 8]);
                end
            end
        end
    end

    // Pixel-level reference: XOR each set sprite pixel into the screen.
    task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                              input logic [11:0] ia, output bit coll);
        logic [7:0] b;
        int px, py, a, bt;
        coll = 1'b0;
        for (int r = 0; r < int'(n); r++) begin
            b = mem[(int'(ia) + r) % 4096];
            for (int c = 0; c < 8; c++) begin
                if (b[7-c]) begin
                    px = int'(x) % 64 + c;
                    py = int'(y) % 32 + r;
`ifdef DRAW_WRAP_EN
                    px = px % 64;
                    py = py % 32;
`endif
                    if (px < 64 && py < 32) begin
                        a  = py * 8 + px / 8;
                        bt = 7 - px % 8;
                        if (ref_fb[a][bt]) coll = 1'b1;
                        ref_fb[a][bt] = ~ref_fb[a][bt];
                    end
                end
            end
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic issue(input bit is_cls, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] ia, input bit wait_done);
        bit            ec;
        int            el;
        logic [2047:0] ef;
        int            d0;
        bit            seen;
        bit            exp_busy;
        chk("collision_held", 32'(collision), 32'(last_coll));
        if (is_cls) begin
            for (int a = 0; a < 256; a++) ref_fb[a] = 8'h00;
            ec = 1'b0;
            el = (gnt_mode == 0) ? 256 : -1;
        end else begin
            model_draw(x, y, n, ia, ec);
            el = (gnt_mode == 0) ? 6 * int'(n) : -1;
        end
        for (int a = 0; a < 256; a++) ef[a*8 +: 8] = ref_fb[a];
        exp_coll_q.push_back(ec);
        exp_lat_q.push_back(el);
        exp_fb_q.push_back(ef);
        last_coll = ec;
        exp_busy = is_cls || (n != 4'd0);
        d0 = done_cnt;

        @(negedge clk);
        cls = is_cls; start = ~is_cls; x_in = x; y_in = y; n_in = n; i_addr = ia;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        start = 1'b0; cls = 1'b0;
        // Operand changes after acceptance must not matter.
        x_in = 8'($urandom); y_in = 8'($urandom); n_in = 4'($urandom); i_addr = 12'($urandom);
        chk("busy_after_accept", 32'(busy), 32'(exp_busy));
        if (exp_busy) begin
            // Requests while busy must be ignored.
            @(negedge clk);
            start = 1'b1; cls = 1'b1;
            @(negedge clk);
            start = 1'b0; cls = 1'b0;
        end
        if (wait_done) begin
            seen = 1'b0;
            for (int k = 0; k < 4000 && !seen; k++) begin
                @(negedge clk);
                #3;
                if (done_cnt != d0) seen = 1'b1;
            end
            if (!seen) begin
                n_tests++; n_fail++;
                $display("FAIL done_timeout: got no done within 4000 cycles, expected done");
                finish_run();
            end
        end
    endtask

    logic [7:0] glyph [5];

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        glyph[0] = 8'hF0; glyph[1] = 8'h90; glyph[2] = 8'h90; glyph[3] = 8'h90; glyph[4] = 8'hF0;
        for (int r = 0; r < 5; r++) mem[12'h200 + r] = glyph[r];
        mem[12'h300] = 8'hFF;

        // Reset values.
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_collision", 32'(collision), 32'd0);
        chk("rst_strobes", {29'd0, mem_rd, fb_rd, fb_we}, 32'd0);
        chk("rst_addr", {12'd0, mem_addr, fb_addr}, 32'd0);
        chk("rst_wdata", 32'(fb_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clear, then the "0" glyph at the origin, drawn twice.
        gnt_mode = 0;
        issue(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1);
        issue(1'b0, 8'd0, 8'd0, 4'd5, 12'h200, 1'b1);
        for (int r = 0; r < 5; r++) chk("glyph_draw", 32'(fb_mem[r*8]), 32'(glyph[r]));
        chk("glyph_coll", 32'(collision), 32'd0);
        issue(1'b0, 8'd0, 8'd0, 4'd5, 12'h200, 1'b1);
        for (int r = 0; r < 5; r++) chk("glyph_erase", 32'(fb_mem[r*8]), 32'd0);
        chk("glyph_erase_coll", 32'(collision), 32'd1);

        // Right-edge sprite.
        issue(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1);
        we_cnt = 0;
        issue(1'b0, 8'd61, 8'd0, 4'd1, 12'h300, 1'b1);
        chk("edge_byte7", 32'(fb_mem[7]), 32'h07);
`ifdef DRAW_WRAP_EN
        chk("edge_byte0", 32'(fb_mem[0]), 32'hF8);
        chk("edge_writes", we_cnt, 2);
`else
        chk("edge_byte0", 32'(fb_mem[0]), 32'h00);
        chk("edge_writes", we_cnt, 1);
`endif

        // Zero-row draw, then a draw under a toggling grant.
        issue(1'b0, 8'd20, 8'd9, 4'd0, 12'h123, 1'b1);
        gnt_mode = 1;
        issue(1'b0, 8'd13, 8'd7, 4'd2, 12'h200, 1'b1);

        // Randomised draws and clears under varied grant patterns.
        for (int t = 0; t < 24; t++) begin
            gnt_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0)
                issue(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1);
            else
                issue(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom), 1'b1);
        end

        // Abort a clear midway with reset.
        gnt_mode = 0;
        issue(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0);
        repeat (126) @(posedge clk);
        #1;
        chk("mid_clear_we", 32'(fb_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(fb_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(fb_addr), 32'd0);
        exp_coll_q.delete(); exp_lat_q.delete(); exp_fb_q.delete();
        last_coll = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1);
        issue(1'b0, 8'd30, 8'd28, 4'd6, 12'h200, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_coll_q.size(), 0);
        finish_run();
    end

endmodule
